// File: rtl/core88_membridge.sv
// Byte-bus to 16-bit synchronous SRAM bridge for the core88 core.
// One byte access per core step, with a one-word read buffer for fast re-reads.
`timescale 1ns/1ps
module core88_membridge #(
  parameter int unsigned WAIT_STATES = 2,
  parameter bit          HIT_ENABLE  = 1'b1
) (
  input  logic        clock,
  input  logic        resetn,
  input  logic [19:0] address,
  input  logic [7:0]  data,
  input  logic        wreq,
  output logic [7:0]  bus,
  output logic        locked,
  output logic [18:0] sram_addr,
  output logic [15:0] sram_dout,
  input  logic [15:0] sram_din,
  output logic        sram_ce,
  output logic        sram_we,
  output logic [1:0]  sram_be,
  output logic [1:0]  dbg_state
);

  typedef enum logic [1:0] {ST_IDLE, ST_ADDR, ST_WAIT, ST_DONE} state_e;

  localparam logic [3:0] WS = 4'(WAIT_STATES);

  state_e      state_q, state_d;
  logic [7:0]  bus_q, bus_d;
  logic [18:0] sram_addr_q, sram_addr_d;
  logic [15:0] sram_dout_q, sram_dout_d;
  logic        sram_ce_q, sram_ce_d;
  logic        sram_we_q, sram_we_d;
  logic [1:0]  sram_be_q, sram_be_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [19:0] lat_addr_q, lat_addr_d;
  logic [7:0]  lat_data_q, lat_data_d;
  logic        lat_wreq_q, lat_wreq_d;
  logic [15:0] buf_q, buf_d;
  logic [18:0] tag_q, tag_d;
  logic        tag_valid_q, tag_valid_d;
  logic        hit;

  // Step handshake: the core holds address/data/wreq stable while locked=0;
  // locked=1 for exactly one cycle means bus is valid and the core advances.
  assign hit = HIT_ENABLE && !wreq && tag_valid_q && (address[19:1] == tag_q);

  always_comb begin
    state_d     = state_q;
    bus_d       = bus_q;
    sram_addr_d = sram_addr_q;
    sram_dout_d = sram_dout_q;
    sram_ce_d   = sram_ce_q;
    sram_we_d   = sram_we_q;
    sram_be_d   = sram_be_q;
    cnt_d       = cnt_q;
    lat_addr_d  = lat_addr_q;
    lat_data_d  = lat_data_q;
    lat_wreq_d  = lat_wreq_q;
    buf_d       = buf_q;
    tag_d       = tag_q;
    tag_valid_d = tag_valid_q;
    case (state_q)
      ST_IDLE: state_d = ST_ADDR;
      ST_ADDR: begin
        lat_addr_d = address;
        lat_data_d = data;
        lat_wreq_d = wreq;
        if (hit) begin
          bus_d   = address[0] ? buf_q[15:8] : buf_q[7:0];
          state_d = ST_DONE;
        end else begin
          sram_addr_d = address[19:1];
          sram_be_d   = address[0] ? 2'b10 : 2'b01;
          sram_dout_d = {data, data};
          sram_ce_d   = 1'b1;
          sram_we_d   = wreq;
          cnt_d       = WS;
          state_d     = ST_WAIT;
        end
      end
      ST_WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q <= 4'd1) begin
          if (!lat_wreq_q) begin
            buf_d       = sram_din;
            tag_d       = lat_addr_q[19:1];
            tag_valid_d = 1'b1;
            bus_d       = lat_addr_q[0] ? sram_din[15:8] : sram_din[7:0];
          end else if (tag_valid_q && (tag_q == lat_addr_q[19:1])) begin
            // Write-through keeps a matching buffered word coherent; no allocation.
            if (lat_addr_q[0]) buf_d[15:8] = lat_data_q;
            else               buf_d[7:0]  = lat_data_q;
          end
          sram_ce_d = 1'b0;
          sram_we_d = 1'b0;
          sram_be_d = 2'b00;
          state_d   = ST_DONE;
        end
      end
      ST_DONE: state_d = ST_ADDR;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q     <= ST_IDLE;
      bus_q       <= 8'h00;
      sram_addr_q <= '0;
      sram_dout_q <= '0;
      sram_ce_q   <= 1'b0;
      sram_we_q   <= 1'b0;
      sram_be_q   <= 2'b00;
      cnt_q       <= '0;
      lat_addr_q  <= '0;
      lat_data_q  <= '0;
      lat_wreq_q  <= 1'b0;
      buf_q       <= '0;
      tag_q       <= '0;
      tag_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      bus_q       <= bus_d;
      sram_addr_q <= sram_addr_d;
      sram_dout_q <= sram_dout_d;
      sram_ce_q   <= sram_ce_d;
      sram_we_q   <= sram_we_d;
      sram_be_q   <= sram_be_d;
      cnt_q       <= cnt_d;
      lat_addr_q  <= lat_addr_d;
      lat_data_q  <= lat_data_d;
      lat_wreq_q  <= lat_wreq_d;
      buf_q       <= buf_d;
      tag_q       <= tag_d;
      tag_valid_q <= tag_valid_d;
    end
  end

  assign bus       = bus_q;
  assign locked    = (state_q == ST_DONE);
  assign sram_addr = sram_addr_q;
  assign sram_dout = sram_dout_q;
  assign sram_ce   = sram_ce_q;
  assign sram_we   = sram_we_q;
  assign sram_be   = sram_be_q;
  assign dbg_state = state_q;

endmodule
